// File: rtl/datapath_controller.sv
// Instruction register, decoder and Moore sequencer for the register-file/ALU datapath.
// Latches an instruction in WAIT and steps the datapath through it one strobe per cycle.
module datapath_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_GET_A,
      S_GET_B,
      S_ALU,
      S_WRITE_REG,
      S_WRITE_IMM
   } state_t;

   typedef enum logic [2:0] {
      I_ILLEGAL,
      I_MOV_IMM,
      I_MOV_REG,
      I_ADD,
      I_CMP,
      I_AND,
      I_MVN
   } instr_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   instr_t      instr;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn, rd, rm;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign rm     = ir_q[2:0];

   assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
   assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
   assign shift  = ir_q[4:3];
   assign ALUop  = op;

   always_comb begin
      instr = I_ILLEGAL;
      case (opcode)
         3'b110: begin
            if (op == 2'b10)      instr = I_MOV_IMM;
            else if (op == 2'b00) instr = I_MOV_REG;
            else                  instr = I_ILLEGAL;
         end
         3'b101: begin
            case (op)
               2'b00:   instr = I_ADD;
               2'b01:   instr = I_CMP;
               2'b10:   instr = I_AND;
               default: instr = I_MVN;
            endcase
         end
         default: instr = I_ILLEGAL;
      endcase
   end

   // IR only accepts a new word while idle, so an in-flight instruction is never disturbed.
   always_comb begin
      ir_d = ir_q;
      if (load && (state_q == S_WAIT)) begin
         ir_d = in;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT: begin
            if (s) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (instr)
               I_MOV_IMM:                 state_d = S_WRITE_IMM;
               I_MOV_REG, I_MVN:          state_d = S_GET_B;
               I_ADD, I_CMP, I_AND:       state_d = S_GET_A;
               default:                   state_d = S_WAIT;
            endcase
         end
         S_GET_A:     state_d = S_GET_B;
         S_GET_B:     state_d = S_ALU;
         S_ALU: begin
            if (instr == I_CMP) state_d = S_WAIT;
            else                state_d = S_WRITE_REG;
         end
         S_WRITE_REG: state_d = S_WAIT;
         S_WRITE_IMM: state_d = S_WAIT;
         default:     state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      w        = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      vsel     = 2'b00;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      case (state_q)
         S_WAIT: w = 1'b1;
         S_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         S_ALU: begin
            // MOV reg runs through the adder with A forced to zero.
            asel = (instr == I_MOV_REG);
            if (instr == I_CMP) loads = 1'b1;
            else                loadc = 1'b1;
         end
         S_WRITE_REG: begin
            vsel     = 2'b00;
            writenum = rd;
            write    = 1'b1;
         end
         S_WRITE_IMM: begin
            vsel     = 2'b10;
            writenum = rn;
            write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: a behavioural datapath is driven by the controller's strobes and
// register results are compared against an instruction-level model of the ISA.
module tb_datapath_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr_in;
   logic        load;
   logic        s;
   logic        w;
   logic [15:0] sximm8, sximm5;
   logic [1:0]  shift, ALUop;
   logic [2:0]  readnum, writenum;
   logic        write;
   logic [1:0]  vsel;
   logic        loada, loadb, loadc, loads, asel, bsel;

   int checks   = 0;
   int failures = 0;

   datapath_controller dut (
      .clk      (clk),
      .reset    (reset),
      .in       (instr_in),
      .load     (load),
      .s        (s),
      .w        (w),
      .sximm8   (sximm8),
      .sximm5   (sximm5),
      .shift    (shift),
      .ALUop    (ALUop),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .vsel     (vsel),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] do_shift(input logic [15:0] x, input logic [1:0] sh);
      case (sh)
         2'd0:    return x;
         2'd1:    return x * 16'd2;
         2'd2:    return x / 16'd2;
         default: return 16'($signed(x) >>> 1);
      endcase
   endfunction

   // Behavioural datapath reacting to the controller's strobes.
   logic [15:0] rf [8] = '{default: '0};
   logic [15:0] a_r = '0, b_r = '0, c_r = '0;
   logic        z_r = 1'b0;
   logic [15:0] ain, bin, alu_out, wb;

   always_comb begin
      ain = asel ? 16'h0 : a_r;
      bin = bsel ? sximm5 : do_shift(b_r, shift);
      case (ALUop)
         2'd0:    alu_out = ain + bin;
         2'd1:    alu_out = ain - bin;
         2'd2:    alu_out = ain & bin;
         default: alu_out = ~bin;
      endcase
      case (vsel)
         2'b00:   wb = c_r;
         2'b10:   wb = sximm8;
         default: wb = 16'h0;
      endcase
   end

   always @(posedge clk) begin
      if (loada) a_r <= rf[readnum];
      if (loadb) b_r <= rf[readnum];
      if (loadc) c_r <= alu_out;
      if (loads) z_r <= (alu_out == 16'h0);
      if (write) rf[writenum] <= wb;
   end

   // Instruction-level reference: register file and zero flag.
   logic [15:0] mreg [8] = '{default: '0};
   logic        mz = 1'b0;

   localparam int K_ILL = 0, K_MOVI = 1, K_MOVR = 2, K_ADD = 3, K_CMP = 4, K_AND = 5, K_MVN = 6;

   function automatic int classify(input logic [15:0] ins);
      logic [4:0] key;
      key = ins[15:11];
      case (key)
         5'b11010: return K_MOVI;
         5'b11000: return K_MOVR;
         5'b10100: return K_ADD;
         5'b10101: return K_CMP;
         5'b10110: return K_AND;
         5'b10111: return K_MVN;
         default:  return K_ILL;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_instr(input logic [15:0] ins, input int unsigned junk_cyc,
                            input int unsigned rst_cyc, input bit hold_s);
      int          kind;
      logic [2:0]  rn, rd, rm;
      logic [1:0]  sh, op;
      logic [15:0] sv, diff;
      int unsigned lat, exp_lat;
      int unsigned nw, na, nb, nc, ns;
      int unsigned ew, ea, eb, ec, es;
      bit          aborted;
      kind = classify(ins);
      rn = ins[10:8]; rd = ins[7:5]; rm = ins[2:0]; sh = ins[4:3]; op = ins[12:11];
      lat = 0; nw = 0; na = 0; nb = 0; nc = 0; ns = 0; aborted = 1'b0;

      chk("idle_before", 32'(w), 32'd1);
      instr_in = ins; load = 1'b1; s = 1'b1;
      @(negedge clk);
      load = 1'b0; s = hold_s; instr_in = 16'($urandom);
      for (int unsigned k = 1; k <= 20 && lat == 0 && !aborted; k++) begin
         load = 1'b0;
         if (w) begin
            lat = k;
            s = 1'b0;
            chk("idle_strobes", 32'({write, loada, loadb, loadc, loads}), 32'd0);
         end else begin
            if (write) begin
               nw++;
               chk("vsel", 32'(vsel), (kind == K_MOVI) ? 32'd2 : 32'd0);
               chk("writenum", 32'(writenum), (kind == K_MOVI) ? 32'(rn) : 32'(rd));
            end
            if (loada) begin na++; chk("readnum_a", 32'(readnum), 32'(rn)); end
            if (loadb) begin nb++; chk("readnum_b", 32'(readnum), 32'(rm)); end
            if (loadc) nc++;
            if (loads) ns++;
            if (loadc || loads) begin
               chk("alu_shift", 32'(shift), 32'(sh));
               chk("alu_op", 32'(ALUop), 32'(op));
               chk("alu_asel", 32'(asel), (kind == K_MOVR) ? 32'd1 : 32'd0);
               chk("alu_bsel", 32'(bsel), 32'd0);
            end
            if (k == junk_cyc) begin
               instr_in = 16'hD1FF; load = 1'b1;
            end
            if (k == rst_cyc) begin
               reset = 1'b1;
               #1;
               chk("rst_w", 32'(w), 32'd1);
               chk("rst_strobes", 32'({write, loada, loadb, loadc, loads}), 32'd0);
               chk("rst_sximm8", 32'(sximm8), 32'd0);
               #1;
               reset = 1'b0;
               s = 1'b0;
               aborted = 1'b1;
            end
            if (!aborted) @(negedge clk);
         end
      end
      load = 1'b0;

      if (aborted) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) chk($sformatf("reg%0d_after_reset", i), 32'(rf[i]), 32'(mreg[i]));
         return;
      end

      sv = do_shift(mreg[rm], sh);
      ew = 0; ea = 0; eb = 0; ec = 0; es = 0;
      case (kind)
         K_MOVI: begin exp_lat = 3; ew = 1; mreg[rn] = {{8{ins[7]}}, ins[7:0]}; end
         K_MOVR: begin exp_lat = 5; ew = 1; eb = 1; ec = 1; mreg[rd] = sv; end
         K_MVN:  begin exp_lat = 5; ew = 1; eb = 1; ec = 1; mreg[rd] = ~sv; end
         K_ADD:  begin exp_lat = 6; ew = 1; ea = 1; eb = 1; ec = 1; mreg[rd] = mreg[rn] + sv; end
         K_AND:  begin exp_lat = 6; ew = 1; ea = 1; eb = 1; ec = 1; mreg[rd] = mreg[rn] & sv; end
         K_CMP:  begin exp_lat = 5; ea = 1; eb = 1; es = 1; diff = mreg[rn] - sv; mz = (diff == 16'h0); end
         default: exp_lat = 2;
      endcase

      chk("latency", lat, exp_lat);
      chk("n_write", nw, ew);
      chk("n_loada", na, ea);
      chk("n_loadb", nb, eb);
      chk("n_loadc", nc, ec);
      chk("n_loads", ns, es);
      chk("sximm8", 32'(sximm8), 32'({{8{ins[7]}}, ins[7:0]}));
      chk("sximm5", 32'(sximm5), 32'({{11{ins[4]}}, ins[4:0]}));
      chk("shift", 32'(shift), 32'(sh));
      chk("aluop", 32'(ALUop), 32'(op));
      for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), 32'(rf[i]), 32'(mreg[i]));
      if (kind == K_CMP) chk("zflag", 32'(z_r), 32'(mz));
   endtask

   initial begin
      logic [15:0] ri;
      logic [4:0]  keys [6];
      keys = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

      reset = 1'b1; load = 1'b0; s = 1'b0; instr_in = 16'h0;
      #1;
      chk("reset_w", 32'(w), 32'd1);
      chk("reset_strobes", 32'({write, loada, loadb, loadc, loads, asel, bsel}), 32'd0);
      chk("reset_sel", 32'({vsel, readnum, writenum}), 32'd0);
      chk("reset_sximm8", 32'(sximm8), 32'd0);
      chk("reset_fields", 32'({sximm5, shift, ALUop}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_instr(16'hD007, 0, 0, 1'b0);
      run_instr(16'hD102, 0, 0, 1'b0);
      run_instr(16'hA148, 0, 0, 1'b0);
      chk("add_r2_is_16", 32'(rf[2]), 32'd16);
      run_instr(16'hA801, 0, 0, 1'b0);
      run_instr(16'h0000, 0, 0, 1'b0);
      run_instr(16'hA148, 3, 0, 1'b0);
      run_instr(16'hD005, 0, 0, 1'b1);
      run_instr(16'hA148, 0, 3, 1'b0);
      chk("r2_kept_after_reset", 32'(rf[2]), 32'd16);

      for (int n = 0; n < 50; n++) begin
         ri = 16'($urandom);
         if ($urandom_range(0, 7) != 0) ri[15:11] = keys[$urandom_range(0, 5)];
         else if (classify(ri) != K_ILL) ri[15:13] = 3'b000;
         run_instr(ri, 0, 0, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/datapath_controller.md
# datapath_controller

Instruction register, decoder and Moore FSM that sequence the register-file/ALU datapath. It latches a 16-bit instruction and, after a start pulse, issues the multi-cycle control strobes that execute it: `vsel`, `write`, `readnum`/`writenum`, `loada`/`loadb`, `asel`/`bsel`, `loadc` and `loads`. It also supplies the decoded `shift`, `ALUop`, `sximm8` and `sximm5` fields. The datapath's `mdata` and `PC` inputs are outside this block's scope.

## Interface
No parameters. Clock domain: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock, shared with the datapath
- `reset`  in  1  asynchronous, active-high; forces IR and FSM to reset state
- `in`  in  16  instruction word
- `load`  in  1  IR load enable
- `s`  in  1  start request
- `w`  out  1  idle flag; 1 only in WAIT
- `sximm8`  out  16  {{8{ir[7]}}, ir[7:0]}
- `sximm5`  out  16  {{11{ir[4]}}, ir[4:0]}
- `shift`  out  2  ir[4:3]
- `ALUop`  out  2  ir[12:11]
- `readnum`  out  3  register-file read index
- `writenum`  out  3  register-file write index
- `write`  out  1  register-file write enable
- `vsel`  out  2  writeback select: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  pipeline/status load enables
- `asel`  out  1  1 = ALU A operand forced to zero
- `bsel`  out  1  1 = ALU B operand is sximm5

## Operation
- **IR fields**
  - opcode = ir[15:13], op = ir[12:11]
  - Rn = ir[10:8], Rd = ir[7:5], Rm = ir[2:0]
- **Supported instructions**
  - 110/10: MOV Rn,#imm8
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
  - Every other opcode/op pair is illegal.
- **IR loading:** IR loads `in` on a clock edge only when `load`=1 and state = WAIT. Otherwise `load` is ignored.
- **FSM states and outputs.** Outputs are a Moore function of state and IR. Any strobe not listed is 0.
  - WAIT: `w`=1. `s`=1 → DECODE.
  - DECODE: no strobes.
    - MOV imm → WRITE_IMM
    - MOV reg or MVN → GET_B
    - ADD, CMP or AND → GET_A
    - illegal → WAIT
  - GET_A: `readnum`=Rn, `loada`=1 → GET_B.
  - GET_B: `readnum`=Rm, `loadb`=1 → ALU.
  - ALU: `bsel`=0; `asel`=1 for MOV reg, else 0.
    - CMP: `loads`=1, `loadc`=0 → WAIT.
    - All others: `loadc`=1 → WRITE_REG.
  - WRITE_REG: `vsel`=00, `writenum`=Rd, `write`=1 → WAIT.
  - WRITE_IMM: `vsel`=10, `writenum`=Rn, `write`=1 → WAIT.
- **MOV reg:** executes as ADD (op=00) with A forced to zero, so the result is 0 + shifted Rm.
- **Idle defaults:** outside the states above, `readnum`=`writenum`=0, `vsel`=00, `asel`=`bsel`=0.
- **Reset values:** IR=0, state=WAIT, `w`=1, all strobes 0, and all decoded outputs 0.
- **`s` and `load` together in WAIT:** IR captures the new word and the FSM enters DECODE. DECODE then uses the new word.
- **`s` outside WAIT:** ignored; starts are not queued.
- **Reset mid-instruction:** reset takes effect immediately. Any pending `write`/`loadc`/`loads` is dropped, and `w` rises without waiting for a clock edge.

## Timing
Edge 0 is the edge that samples `s`=1 in WAIT. "Cycle k" is the cycle following edge k-1.
- **MOV imm:** DECODE in cycle 1, WRITE_IMM in cycle 2 (register written at edge 2). `w`=1 from cycle 3.
- **MOV reg / MVN:** DECODE, GET_B, ALU, WRITE_REG in cycles 1–4. `w`=1 from cycle 5.
- **ADD / AND:** DECODE, GET_A, GET_B, ALU, WRITE_REG in cycles 1–5. `w`=1 from cycle 6.
- **CMP:** DECODE, GET_A, GET_B, ALU in cycles 1–4 (status loaded at edge 4). `w`=1 from cycle 5.
- **Illegal opcode:** DECODE in cycle 1, then WAIT from cycle 2.
- **Strobe width:** every strobe is high for exactly one cycle per instruction.
- **Back-to-back issue:** `s` may be held high. The next instruction starts at the first edge at which the FSM is in WAIT.

## Test plan
Each scenario runs with the controller connected to the datapath.
- **Reset:** assert `reset` with no clock edge → `w`=1, all strobes 0, `sximm8`=0.
- **MOV imm pair:** load 0xD007 and pulse `s`, then load 0xD102 and pulse `s` → R0=7 and R1=2. `write` is high exactly once per instruction; `w` returns to 1 three cycles after each start.
- **ADD with shift:** after the MOV pair, load 0xA148 (ADD R2,R1,R0,LSL#1) and pulse `s`.
  - R2=16.
  - `loada` is high with `readnum`=1; `loadb` is high with `readnum`=0.
  - `shift`=01 in ALU state.
  - `w`=1 six cycles after the start.
- **CMP:** load 0xA801 (CMP R0,R1) and pulse `s` → `loads` pulses once, `loadc` and `write` stay 0, and no register changes.
- **Illegal opcode and ignored load:** load 0x0000 and pulse `s` → FSM returns to WAIT after 2 cycles with no strobes. In a separate run, assert `load` with 0xD1FF while in GET_B → IR is unchanged.
- **Reset mid-op:** assert `reset` during GET_B of ADD → `w`=1 immediately, `write` never asserted, R2 unchanged.
